conv_dense_vmult_pipe: RTL and testbench

//  Parametrised lane-parallel fixed-point vector multiplier for conv/dense layers. Next generation of the 25-lane Q8.8 DSP array.

---
 rtl/conv_vmult_pkg.sv | 26 ++
 rtl/conv_vmult_lane.sv | 33 +++
 rtl/conv_dense_vmult_pipe.sv | 126 ++++++++++++
 tb/tb_conv_dense_vmult_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_vmult_pkg.sv
// Shared constants and the overflow helper for the lane-parallel vector multiplier.
// Build option CONV_VMULT_SAT_EN: clamp out-of-range results instead of wrapping.
package conv_vmult_pkg;

  localparam logic MODE_ELEM = 1'b0;
  localparam logic MODE_DOT  = 1'b1;

  localparam int DEF_DW   = 16;
  localparam int DEF_FRAC = 8;

  // Brings a wide signed value into the signed dw-bit range; the caller keeps the low dw bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value, input int dw);
`ifdef CONV_VMULT_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
`else
    return (value <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/conv_vmult_lane.sv
// One signed DWxDW multiplier lane: MULT_LAT product registers behind a DSP clock enable,
// with inactive lanes forced to a zero product.
module conv_vmult_lane
  import conv_vmult_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int MULT_LAT = 3
) (
  input  logic                   clk,
  input  logic                   ce,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] p
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0] prod_p [MULT_LAT];

  // Stage 0 multiplies, stages 1..MULT_LAT-1 retime the product
  always_ff @(posedge clk) begin
    if (ce) begin
      prod_p[0] <= en ? PW'(a) * PW'(b) : '0;
      for (int k = 1; k < MULT_LAT; k++) begin
        prod_p[k] <= prod_p[k-1];
      end
    end
  end

  assign p = prod_p[MULT_LAT-1];

endmodule

// File: rtl/conv_dense_vmult_pipe.sv
// Lane-parallel Q-format vector multiplier (element-wise or dot product) with halt, lane mask,
// per-group DSP enables and last-flag passthrough. Build option CONV_VMULT_SAT_EN selects saturation.
module conv_dense_vmult_pipe
  import conv_vmult_pkg::*;
#(
  parameter int LANES    = 25,
  parameter int DW       = DEF_DW,
  parameter int FRAC     = DEF_FRAC,
  parameter int MULT_LAT = 3,
  parameter int GRP      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_v,
  input  logic                halt,
  input  logic                in_last,
  input  logic                mode,
  input  logic [LANES-1:0]    lane_mask,
  input  logic [LANES*DW-1:0] in_fea_w,
  input  logic [LANES*DW-1:0] a_mx_w,
  output logic [LANES*DW-1:0] out_res_w,
  output logic                out_v,
  output logic                out_last,
  output logic                busy
);

  localparam int LAT  = MULT_LAT + 1;
  localparam int NGRP = (LANES + GRP - 1) / GRP;
  localparam int PW   = 2 * DW;
  localparam int SW   = PW + $clog2(LANES);

  logic [LAT-1:0]       vld;
  logic [LAT-1:0]       last_p;
  logic [MULT_LAT-1:0]  mode_p;
  logic [LANES-1:0]     mask_p [MULT_LAT];
  logic [NGRP-1:0]      act_g;
  logic [NGRP-1:0]      ce_g;

  logic signed [PW-1:0] prod   [LANES];
  logic signed [PW-1:0] prod_m [LANES];
  logic signed [SW-1:0] sum;
  logic [LANES*DW-1:0]  res_nxt;

  // Control pipeline: valid and last are reset, halt freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      last_p <= '0;
    end else if (!halt) begin
      vld    <= {vld[LAT-2:0], in_v};
      last_p <= {last_p[LAT-2:0], in_last};
    end
  end

  // Per-vector mode and mask travel alongside the lane products
  always_ff @(posedge clk) begin
    if (!halt) begin
      mode_p[0] <= mode;
      mask_p[0] <= lane_mask;
      for (int k = 1; k < MULT_LAT; k++) begin
        mode_p[k] <= mode_p[k-1];
        mask_p[k] <= mask_p[k-1];
      end
    end
  end

  // A group only clocks while some vector in its multiplier pipe (or entering it) uses one of its
  // lanes; stale contents of an idle group are discarded later through the carried mask.
  always_comb begin
    act_g = '0;
    for (int l = 0; l < LANES; l++) begin
      act_g[l/GRP] |= in_v & lane_mask[l];
      for (int k = 0; k < MULT_LAT; k++) begin
        act_g[l/GRP] |= vld[k] & mask_p[k][l];
      end
    end
    ce_g = act_g & {NGRP{~halt & (|vld | in_v)}};
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conv_vmult_lane #(
      .DW       (DW),
      .MULT_LAT (MULT_LAT)
    ) u_lane (
      .clk (clk),
      .ce  (ce_g[i/GRP]),
      .en  (lane_mask[i]),
      .a   (in_fea_w[i*DW +: DW]),
      .b   (a_mx_w[i*DW +: DW]),
      .p   (prod[i])
    );
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_m[i] = mask_p[MULT_LAT-1][i] ? prod[i] : '0;
    end
  end

  always_comb begin
    sum     = '0;
    res_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SW'(prod_m[i]);
      res_nxt[i*DW +: DW] = DW'(sat_trunc(64'(prod_m[i] >>> FRAC), DW));
    end
    if (mode_p[MULT_LAT-1] == MODE_DOT) begin
      res_nxt = '0;
      res_nxt[DW-1:0] = DW'(sat_trunc(64'(sum >>> FRAC), DW));
    end
  end

  // Output stage: same depth in both modes; bubbles leave a zero vector
  always_ff @(posedge clk) begin
    if (rst) begin
      out_res_w <= '0;
    end else if (!halt) begin
      out_res_w <= vld[LAT-2] ? res_nxt : '0;
    end
  end

  assign out_v    = vld[LAT-1] & ~halt;
  assign out_last = last_p[LAT-1] & out_v;
  assign busy     = |vld;

endmodule

// File: tb/tb_conv_dense_vmult_pipe.sv
// Self-checking bench for conv_dense_vmult_pipe: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_conv_dense_vmult_pipe;

  localparam int LANES = 25;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int LAT   = 4;
  localparam int VW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_v;
  logic          halt;
  logic          in_last;
  logic          mode;
  logic [LANES-1:0] lane_mask;
  logic [VW-1:0] in_fea_w;
  logic [VW-1:0] a_mx_w;
  logic [VW-1:0] out_res_w;
  logic          out_v;
  logic          out_last;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [VW-1:0] res;
    logic          last;
    int            age;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  conv_dense_vmult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_v      (in_v),
    .halt      (halt),
    .in_last   (in_last),
    .mode      (mode),
    .lane_mask (lane_mask),
    .in_fea_w  (in_fea_w),
    .a_mx_w    (a_mx_w),
    .out_res_w (out_res_w),
    .out_v     (out_v),
    .out_last  (out_last),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] fit(input longint v);
    longint r;
    r = v;
`ifdef CONV_VMULT_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[DW-1:0];
  endfunction

  function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] f, input logic [VW-1:0] w,
                                            input logic [LANES-1:0] m, input logic md);
    logic [VW-1:0] r;
    longint p;
    longint s;
    r = '0;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      p = longint'($signed(f[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
      if (!m[i]) p = 0;
      s = s + p;
      r[i*DW +: DW] = fit(p >>> FRAC);
    end
    if (md) begin
      r = '0;
      r[DW-1:0] = fit(s >>> FRAC);
    end
    return r;
  endfunction

  task automatic idle_inputs();
    rst       = 1'b0;
    in_v      = 1'b0;
    halt      = 1'b0;
    in_last   = 1'b0;
    mode      = 1'b0;
    lane_mask = '1;
    in_fea_w  = '0;
    a_mx_w    = '0;
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] f, input logic [DW-1:0] w);
    in_fea_w[i*DW +: DW] = f;
    a_mx_w[i*DW +: DW]   = w;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst  = 1'b1;
    in_v = 1'b1;
    for (int i = 0; i < LANES; i++) set_lane(i, 16'($urandom), 16'($urandom));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_v !== 1'b0) begin n_bad++; $display("FAIL reset_out_v: got %b want 0", out_v); end
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_vec++;
    if (out_res_w !== '0) begin n_bad++; $display("FAIL reset_out_res: got %h want 0", out_res_w); end
    @(posedge clk);
    #1;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_elem();
    logic [VW-1:0] exp;
    exp = '0;
    exp[3*DW +: DW] = 16'h0600;
    exp[0*DW +: DW] = 16'hFF80;
`ifdef CONV_VMULT_SAT_EN
    exp[1*DW +: DW] = 16'h7FFF;
`else
    exp[1*DW +: DW] = 16'hFC00;
`endif
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c == 0) begin
        in_v = 1'b1;
        set_lane(3, 16'h0200, 16'h0300);
        set_lane(0, 16'hFF00, 16'h0080);
        set_lane(1, 16'h7F00, 16'h0400);
      end
      @(negedge clk);
      n_vec++;
      if (out_v !== 1'(c == 4)) begin
        n_bad++; $display("FAIL elem_out_v c%0d: got %b want %b", c, out_v, c == 4);
      end
      if (c == 4) begin
        n_vec++;
        if (out_res_w !== exp) begin
          n_bad++; $display("FAIL elem_data: got %h want %h", out_res_w, exp);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_dot();
    logic [VW-1:0] exp;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c == 0 || c == 1) begin
        in_v = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < LANES; i++) set_lane(i, 16'h0100, 16'h0100);
        if (c == 1) lane_mask = 25'h0000FFF;
      end
      @(negedge clk);
      n_vec++;
      if (out_v !== 1'(c == 4 || c == 5)) begin
        n_bad++; $display("FAIL dot_out_v c%0d: got %b want %b", c, out_v, (c == 4 || c == 5));
      end
      if (c == 4 || c == 5) begin
        exp = '0;
        exp[DW-1:0] = (c == 4) ? 16'h1900 : 16'h0C00;
        n_vec++;
        if (out_res_w !== exp) begin
          n_bad++; $display("FAIL dot_data c%0d: got %h want %h", c, out_res_w, exp);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    logic [VW-1:0] exp;
    exp = '0;
    exp[5*DW +: DW] = 16'h0200;
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      if (c == 0) begin
        in_v = 1'b1;
        set_lane(5, 16'h0100, 16'h0200);
      end
      if (c >= 2 && c <= 4) halt = 1'b1;
      if (c == 3) begin
        in_v = 1'b1;
        set_lane(7, 16'h0300, 16'h0300);
      end
      @(negedge clk);
      n_vec++;
      if (out_v !== 1'(c == 7)) begin
        n_bad++; $display("FAIL halt_out_v c%0d: got %b want %b", c, out_v, c == 7);
      end
      if (c == 7) begin
        n_vec++;
        if (out_res_w !== exp) begin
          n_bad++; $display("FAIL halt_data: got %h want %h", out_res_w, exp);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] exp;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c == 0) begin
        in_v = 1'b1;
        set_lane(2, 16'h0300, 16'h0100);
      end else if (c == 1) begin
        in_v = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < LANES; i++) set_lane(i, 16'h0100, 16'h0200);
      end else if (c == 2) begin
        in_v    = 1'b1;
        in_last = 1'b1;
        set_lane(4, 16'hFF00, 16'hFF00);
      end
      @(negedge clk);
      n_vec++;
      if (out_v !== 1'(c >= 4 && c <= 6)) begin
        n_bad++; $display("FAIL b2b_out_v c%0d: got %b want %b", c, out_v, (c >= 4 && c <= 6));
      end
      n_vec++;
      if (out_last !== 1'(c == 6)) begin
        n_bad++; $display("FAIL b2b_out_last c%0d: got %b want %b", c, out_last, c == 6);
      end
      if (c >= 4 && c <= 6) begin
        exp = '0;
        if (c == 4) exp[2*DW +: DW] = 16'h0300;
        if (c == 5) exp[DW-1:0] = 16'h3200;
        if (c == 6) exp[4*DW +: DW] = 16'h0100;
        n_vec++;
        if (out_res_w !== exp) begin
          n_bad++; $display("FAIL b2b_data c%0d: got %h want %h", c, out_res_w, exp);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c <= 1) begin
        in_v = 1'b1;
        for (int i = 0; i < LANES; i++) set_lane(i, 16'($urandom), 16'($urandom));
      end
      if (c == 2) rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'(c == 1 || c == 2)) begin
        n_bad++; $display("FAIL rstmid_busy c%0d: got %b want %b", c, busy, (c == 1 || c == 2));
      end
      n_vec++;
      if (out_v !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_out_v c%0d: got %b want 0", c, out_v);
      end
      if (c >= 3) begin
        n_vec++;
        if (out_res_w !== '0) begin
          n_bad++; $display("FAIL rstmid_out_res c%0d: got %h want 0", c, out_res_w);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    ent_t e;
    logic exp_v;
    int   tmp;
    int   n;
    n = 600;
    q.delete();
    for (int c = 0; c < n; c++) begin
      idle_inputs();
      if (c < n - 10) begin
        in_v    = ($urandom_range(0, 9) < 7);
        halt    = ($urandom_range(0, 9) < 2);
        mode    = 1'($urandom);
        in_last = 1'($urandom);
        for (int g = 0; g < (LANES + 3) / 4; g++) begin
          for (int l = g * 4; l < g * 4 + 4 && l < LANES; l++) begin
            lane_mask[l] = (g % 2 == 0 || $urandom_range(0, 1) == 1) ? 1'($urandom) : 1'b0;
          end
        end
        if ($urandom_range(0, 7) == 0) lane_mask = '1;
        for (int i = 0; i < LANES; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            set_lane(i, 16'($urandom), 16'($urandom));
          end else begin
            tmp = int'($urandom_range(0, 2048)) - 1024;
            in_fea_w[i*DW +: DW] = 16'(tmp);
            tmp = int'($urandom_range(0, 2048)) - 1024;
            a_mx_w[i*DW +: DW] = 16'(tmp);
          end
        end
      end
      @(negedge clk);
      exp_v = (q.size() > 0) && (q[0].age == LAT - 1) && !halt;
      n_vec++;
      if (out_v !== exp_v) begin
        n_bad++; $display("FAIL rand_out_v c%0d: got %b want %b", c, out_v, exp_v);
      end
      n_vec++;
      if (out_last !== (exp_v & q[0].last)) begin
        n_bad++; $display("FAIL rand_out_last c%0d: got %b want %b", c, out_last, exp_v & q[0].last);
      end
      n_vec++;
      if (busy !== 1'(q.size() > 0)) begin
        n_bad++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, q.size() > 0);
      end
      if (exp_v) begin
        n_vec++;
        if (out_res_w !== q[0].res) begin
          n_bad++; $display("FAIL rand_data c%0d: got %h want %h", c, out_res_w, q[0].res);
        end
      end
      if (!halt) begin
        if (exp_v) void'(q.pop_front());
        for (int j = 0; j < q.size(); j++) q[j].age = q[j].age + 1;
        if (in_v) begin
          e.res  = ref_vec(in_fea_w, a_mx_w, lane_mask, mode);
          e.last = in_last;
          e.age  = 0;
          q.push_back(e);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_elem();
    test_dot();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
